// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the oscilloscope sample RAM: ring-buffer capture around a
// level/edge trigger with programmable pre-trigger history, then oldest-first readout.
module capture_ctrl #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 force_trig_i,
    input  logic [ADDR_SIZE-1:0] pretrig_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic                 trig_rising_i,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    output logic                 mem_w_en_o,
    output logic [ADDR_SIZE-1:0] mem_w_addr_o,
    output logic [DATA_SIZE-1:0] mem_w_data_o,
    output logic [ADDR_SIZE-1:0] mem_r_addr_o,
    input  logic [DATA_SIZE-1:0] mem_r_data_i,
    output logic                 rd_valid_o,
    output logic [DATA_SIZE-1:0] rd_data_o,
    output logic                 rd_last_o,
    input  logic                 rd_ready_i,
    output logic                 busy_o,
    output logic                 triggered_o,
    output logic [ADDR_SIZE-1:0] trig_addr_o
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam int CW    = ADDR_SIZE + 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, POST, READ} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] w_ptr_q, r_ptr_q, pretrig_q, trig_addr_q;
    logic [CW-1:0]        cnt_q;
    logic [DATA_SIZE-1:0] level_q, prev_q;
    logic                 rising_q, prev_valid_q, triggered_q, force_pend_q;

    logic          capturing, wr_en, rise_hit, fall_hit, trig_hit, rd_fire, beat_last;
    logic [CW-1:0] post_init;

    assign capturing = (state_q == ARM) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign wr_en     = capturing && sample_valid_i && !abort_i;
    assign rise_hit  = prev_valid_q && (prev_q < level_q) && (sample_i >= level_q);
    assign fall_hit  = prev_valid_q && (prev_q > level_q) && (sample_i <= level_q);
    assign trig_hit  = (state_q == WAIT_TRIG) && wr_en &&
                       (force_trig_i || force_pend_q || (rising_q ? rise_hit : fall_hit));
    assign post_init = CW'(DEPTH - 1) - CW'(pretrig_q);
    assign rd_fire   = (state_q == READ) && !abort_i && rd_ready_i;
    assign beat_last = (cnt_q == CW'(DEPTH - 1));

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (start_i) state_d = (pretrig_i == '0) ? WAIT_TRIG : ARM;
                ARM:       if (wr_en && (cnt_q + CW'(1) == CW'(pretrig_q))) state_d = WAIT_TRIG;
                WAIT_TRIG: if (trig_hit) state_d = (post_init == '0) ? READ : POST;
                POST:      if (wr_en && (cnt_q == CW'(1))) state_d = READ;
                READ:      if (rd_fire && beat_last) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_ptr_q      <= '0;
            r_ptr_q      <= '0;
            cnt_q        <= '0;
            pretrig_q    <= '0;
            level_q      <= '0;
            rising_q     <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            trig_addr_q  <= '0;
            force_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            if (wr_en) w_ptr_q <= w_ptr_q + ADDR_SIZE'(1);
            case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    pretrig_q    <= pretrig_i;
                    level_q      <= trig_level_i;
                    rising_q     <= trig_rising_i;
                    cnt_q        <= '0;
                    prev_valid_q <= 1'b0;
                    force_pend_q <= 1'b0;
                end
                ARM: begin
                    if (wr_en) cnt_q <= cnt_q + CW'(1);
                    if (force_trig_i) force_pend_q <= 1'b1;
                end
                WAIT_TRIG: begin
                    if (wr_en) begin
                        prev_q       <= sample_i;
                        prev_valid_q <= 1'b1;
                    end else if (force_trig_i) begin
                        force_pend_q <= 1'b1;
                    end
                    if (trig_hit) begin
                        trig_addr_q  <= w_ptr_q;
                        triggered_q  <= 1'b1;
                        force_pend_q <= 1'b0;
                        cnt_q        <= post_init;
                        // With no post samples the trigger write is the last one.
                        if (post_init == '0) begin
                            r_ptr_q <= w_ptr_q + ADDR_SIZE'(1);
                            cnt_q   <= '0;
                        end
                    end
                end
                POST: if (wr_en) begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        r_ptr_q <= w_ptr_q + ADDR_SIZE'(1);
                        cnt_q   <= '0;
                    end
                end
                READ: if (rd_fire) begin
                    r_ptr_q <= r_ptr_q + ADDR_SIZE'(1);
                    cnt_q   <= cnt_q + CW'(1);
                    if (beat_last) triggered_q <= 1'b0;
                end
                default: ;
            endcase
            if (abort_i) triggered_q <= 1'b0;
        end
    end

    assign mem_w_en_o   = wr_en;
    assign mem_w_addr_o = w_ptr_q;
    assign mem_w_data_o = sample_i;
    assign mem_r_addr_o = r_ptr_q;
    assign rd_valid_o   = (state_q == READ) && !abort_i;
    assign rd_data_o    = mem_r_data_i;
    assign rd_last_o    = rd_valid_o && beat_last;
    assign busy_o       = (state_q != IDLE);
    assign triggered_o  = triggered_q;
    assign trig_addr_o  = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised bench for capture_ctrl: expected readout windows are derived from the sample
// stream and trigger rules, queued at stimulus time and checked by an independent monitor.
module tb_capture_ctrl;

    localparam int DW    = 12;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, force_trig = 1'b0;
    logic [AW-1:0] pretrig = '0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_rising = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr, trig_addr;
    logic [DW-1:0] mem_w_data, mem_r_data, rd_data;
    logic          rd_valid, rd_last, busy, triggered;
    logic          rd_ready = 1'b0;

    always #5 clk = ~clk;

    capture_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .force_trig_i(force_trig), .pretrig_i(pretrig), .trig_level_i(trig_level),
        .trig_rising_i(trig_rising), .sample_valid_i(sample_valid), .sample_i(sample),
        .mem_w_en_o(mem_w_en), .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data),
        .mem_r_addr_o(mem_r_addr), .mem_r_data_i(mem_r_data), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_ready_i(rd_ready), .busy_o(busy),
        .triggered_o(triggered), .trig_addr_o(trig_addr)
    );

    // Sample RAM: synchronous write, combinational read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    assign mem_r_data = ram[mem_r_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int            n_cmp = 0, n_bad = 0;
    beat_t         exp_q[$];
    logic [DW-1:0] stim[$];
    int            beats_seen = 0;
    int            model_wptr = 0;
    logic [AW-1:0] exp_trig_addr = '0;
    int            ready_mode = 2;
    int            rdy_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready: random, the 1,0,0,1 pattern, or always ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rd_ready = 1'($urandom_range(0, 1));
            1: begin rd_ready = (rdy_k % 4 == 0) || (rdy_k % 4 == 3); rdy_k++; end
            default: rd_ready = 1'b1;
        endcase
    end

    // Monitor: every readout handshake pops one expected beat.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data %0d with no beat expected", rd_data);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                if (beats_seen == 0) begin
                    check("trig_addr", 32'(trig_addr), 32'(exp_trig_addr));
                    check("triggered_in_read", 32'(triggered), 32'(1));
                end
                check("rd_data", 32'(rd_data), 32'(b.data));
                check("rd_last", 32'(rd_last), 32'(b.last));
                beats_seen++;
            end
        end
    end

    function automatic bit crosses(logic [DW-1:0] p, logic [DW-1:0] c, logic [DW-1:0] lvl, bit rise);
        return rise ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl);
    endfunction

    // Index in stim of the trigger sample; the first pre samples only fill history.
    function automatic int find_trig(int pre, logic [DW-1:0] lvl, bit rise, bit frc);
        for (int i = pre; i < stim.size(); i++) begin
            if (frc) return i;
            if (i > pre && crosses(stim[i-1], stim[i], lvl, rise)) return i;
        end
        return -1;
    endfunction

    task automatic start_cap(input int pre, input logic [DW-1:0] lvl, input bit rise, input bit frc);
        @(posedge clk); #1;
        start = 1'b1; pretrig = AW'(pre); trig_level = lvl; trig_rising = rise;
        force_trig = frc; sample_valid = 1'b0; beats_seen = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents n samples from stim with random gaps; the last one is written on the next edge.
    task automatic feed(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) != 0) begin
                sample_valid = 1'b1; sample = stim[k]; k++;
            end else begin
                sample_valid = 1'b0; sample = 12'($urandom);
            end
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (busy && cyc < 3000) begin
            @(posedge clk); #1;
            sample_valid = 1'($urandom_range(0, 1)); sample = 12'($urandom);
            cyc++;
        end
        sample_valid = 1'b1;
        @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'(0));
        check({name, "_no_write_idle"}, 32'(mem_w_en), 32'(0));
        check({name, "_triggered_clear"}, 32'(triggered), 32'(0));
        check({name, "_beats_left"}, 32'(exp_q.size()), 32'(0));
        sample_valid = 1'b0;
    endtask

    task automatic push_window(input int pre, input int t, output int n);
        n = t + DEPTH - pre;
        for (int i = t - pre; i < n; i++) exp_q.push_back(beat_t'{data: stim[i], last: (i == n - 1)});
        exp_trig_addr = AW'((model_wptr + t) % DEPTH);
    endtask

    task automatic do_capture(input int pre, input logic [DW-1:0] lvl, input bit rise, input bit frc,
                              input string name);
        int t, n;
        t = find_trig(pre, lvl, rise, frc);
        if (t < 0 || t + DEPTH - pre > stim.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: stimulus holds no usable trigger", name);
            return;
        end
        push_window(pre, t, n);
        start_cap(pre, lvl, rise, frc);
        feed(n);
        model_wptr = (model_wptr + n) % DEPTH;
        drain(name);
        check({name, "_beat_count"}, 32'(beats_seen), 32'(DEPTH));
    endtask

    task automatic gen_random(output int pre, output logic [DW-1:0] lvl, output bit rise, output bit frc);
        int t;
        do begin
            stim.delete();
            for (int i = 0; i < 120; i++) stim.push_back(12'($urandom));
            pre  = $urandom_range(0, DEPTH - 1);
            lvl  = 12'($urandom_range(200, 3800));
            rise = 1'($urandom_range(0, 1));
            frc  = ($urandom_range(0, 7) == 0);
            t    = find_trig(pre, lvl, rise, frc);
        end while (t < 0 || t + DEPTH - pre > stim.size());
    endtask

    initial begin
        int pre, n, cyc;
        logic [DW-1:0] lvl;
        bit rise, frc;

        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_triggered", 32'(triggered), 32'(0));
        check("rst_trig_addr", 32'(trig_addr), 32'(0));
        check("rst_w_en", 32'(mem_w_en), 32'(0));
        check("rst_w_addr", 32'(mem_w_addr), 32'(0));
        check("rst_r_addr", 32'(mem_r_addr), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_last", 32'(rd_last), 32'(0));
        @(negedge clk); rst_n = 1'b1;

        // Rising ramp: trigger on 100 at address 10, window 60..210.
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(12'(i * 10));
        ready_mode = 2;
        do_capture(4, 12'd100, 1'b1, 1'b0, "ramp");

        // Asynchronous reset while post-trigger samples are still arriving.
        start_cap(2, 12'd100, 1'b1, 1'b0);
        feed(14);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_triggered", 32'(triggered), 32'(0));
        check("arst_trig_addr", 32'(trig_addr), 32'(0));
        check("arst_w_en", 32'(mem_w_en), 32'(0));
        check("arst_w_addr", 32'(mem_w_addr), 32'(0));
        check("arst_rd_valid", 32'(rd_valid), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        model_wptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            sample_valid = 1'($urandom_range(0, 1)); sample = 12'($urandom);
            @(negedge clk);
            check("arst_stays_idle", 32'(busy), 32'(0));
        end
        sample_valid = 1'b0;

        // Forced trigger with no history: first sample at address 0.
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(12'($urandom));
        do_capture(0, 12'd4095, 1'b1, 1'b1, "force");

        // Falling edge with full history and no post samples; the ring wraps.
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(12'($urandom_range(51, 4095)));
        for (int i = 0; i < 10; i++) stim.push_back(12'd40);
        do_capture(15, 12'd50, 1'b0, 1'b0, "falling");

        // Readout with a stalling consumer.
        ready_mode = 1;
        gen_random(pre, lvl, rise, frc);
        do_capture(pre, lvl, rise, frc, "stall");

        // Abort while waiting for a trigger that never comes.
        ready_mode = 0;
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(12'($urandom_range(0, 999)));
        start_cap(3, 12'd4000, 1'b1, 1'b0);
        feed(10);
        @(posedge clk); #1;
        abort = 1'b1; sample_valid = 1'b1; sample = 12'd7;
        @(negedge clk);
        check("abort_wait_no_write", 32'(mem_w_en), 32'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_wait_busy", 32'(busy), 32'(0));
        check("abort_wait_triggered", 32'(triggered), 32'(0));
        check("abort_wait_no_write_after", 32'(mem_w_en), 32'(0));
        sample_valid = 1'b0;
        model_wptr = (model_wptr + 10) % DEPTH;

        // Abort during readout beat 5.
        gen_random(pre, lvl, rise, frc);
        push_window(pre, find_trig(pre, lvl, rise, frc), n);
        start_cap(pre, lvl, rise, frc);
        feed(n);
        model_wptr = (model_wptr + n) % DEPTH;
        cyc = 0;
        while (beats_seen < 5 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("abort_read_reached_beat5", 32'(beats_seen), 32'(5));
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_read_no_valid", 32'(rd_valid), 32'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_read_busy", 32'(busy), 32'(0));
        check("abort_read_triggered", 32'(triggered), 32'(0));
        check("abort_read_beats_left", 32'(exp_q.size()), 32'(DEPTH - 5));
        exp_q.delete();

        // Fresh random captures after the aborts.
        for (int k = 0; k < 6; k++) begin
            ready_mode = (k % 3 == 2) ? 1 : 0;
            gen_random(pre, lvl, rise, frc);
            do_capture(pre, lvl, rise, frc, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
